// File: rtl/nim_spike_scheduler.sv
// Spike scheduler for nim_if: queues spike indices and sweeps all neuron rows once per spike.
// Define NIM_SPIKE_COUNT_EN to add the spike_count output (completed sweeps, wraps at 2^32).
module nim_spike_scheduler #(
   parameter int unsigned NR_DEPTH   = 16,
   parameter int unsigned SR_DEPTH   = 16384,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned TW = $clog2(NR_DEPTH),
   localparam int unsigned SW = $clog2(SR_DEPTH),
   localparam int unsigned PW = $clog2(FIFO_DEPTH),
   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          spike_valid,
   input  logic [SW-1:0] spike_id,
   output logic          spike_ready,
   input  logic          enable,
   output logic          freeze,
   output logic [SW-1:0] spike_index,
   output logic [TW-1:0] time_index,
   output logic          busy,
   output logic          spike_done,
   output logic [LW-1:0] fifo_level
`ifdef NIM_SPIKE_COUNT_EN
   ,
   output logic [31:0]   spike_count
`endif
);

   typedef enum logic [0:0] {StIdle, StSweep} state_t;

   state_t        state;
   logic          ph;
   logic [SW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [LW-1:0] level;
   logic          push;
   logic          pop;
   logic          last_row;

   assign spike_ready = (level != LW'(FIFO_DEPTH));
   assign push        = spike_valid && spike_ready;
   assign last_row    = (time_index == TW'(NR_DEPTH - 1));
   // Pops only happen on the write-phase edge that starts a sweep, never on an empty FIFO.
   assign pop         = ph && enable && (level != '0) && ((state == StIdle) || last_row);
   assign fifo_level  = level;
   assign busy        = (state == StSweep) || (level != '0);

   // Storage needs no reset; pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= spike_id;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= StIdle;
         ph          <= 1'b0;
         freeze      <= 1'b1;
         spike_index <= '0;
         time_index  <= '0;
         spike_done  <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
      end else begin
         ph         <= ~ph;
         spike_done <= 1'b0;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      level <= level + LW'(1);
         else if (!push && pop) level <= level - LW'(1);

         if (ph) begin
            unique case (state)
               StIdle: begin
                  if (pop) begin
                     state       <= StSweep;
                     freeze      <= 1'b0;
                     spike_index <= mem[rd_ptr];
                     time_index  <= '0;
                  end
               end
               StSweep: begin
                  if (!last_row) begin
                     time_index <= time_index + TW'(1);
                  end else begin
                     spike_done <= 1'b1;
                     time_index <= '0;
                     if (pop) begin
                        spike_index <= mem[rd_ptr];
                     end else begin
                        state  <= StIdle;
                        freeze <= 1'b1;
                     end
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

`ifdef NIM_SPIKE_COUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           spike_count <= '0;
      else if (spike_done) spike_count <= spike_count + 32'd1;
   end
`endif

endmodule
